// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Holds the frame FSM encoding, line-option encodings and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic STOP_ONE    = 1'b0;
  localparam logic STOP_TWO    = 1'b1;

  // Callers zero-extend narrower words, which leaves the XOR unchanged.
  function automatic logic parity_calc(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; full is judged before any same-cycle pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == {(AW+1){1'b0}});
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; power-of-two depth makes the wrap implicit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: queued words are serialised with optional parity
// and one or two stop bits, back-to-back while the queue holds data.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int Data_length  = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [Data_length-1:0]       parallel_datain,
  input  logic                         send,
  input  logic                         parity_en,
  input  logic                         parity_type,
  input  logic                         stop_bits,
  output logic                         tx_serialout,
  output logic                         tx_done,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(Data_length);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(Data_length - 1);

  tx_state_t              state;
  tx_state_t              state_next;
  logic [CNT_W-1:0]       baud_cnt;
  logic [CNT_W-1:0]       baud_next;
  logic [3:0]             bit_idx;
  logic [3:0]             bit_next;
  logic [Data_length-1:0] data_q;
  logic [Data_length-1:0] fifo_dout;
  logic                   par_en_q;
  logic                   parity_q;
  logic                   stop2_q;
  logic                   pop;
  logic                   baud_end;
  logic                   line_next;
  logic                   done_next;

  uart_sync_fifo #(
    .WIDTH (Data_length),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (send),
    .pop   (pop),
    .din   (parallel_datain),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_end = (baud_cnt == BAUD_LAST);

  // State register plus frame context captured at pop time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      baud_cnt     <= {CNT_W{1'b0}};
      bit_idx      <= 4'd0;
      data_q       <= {Data_length{1'b0}};
      par_en_q     <= 1'b0;
      parity_q     <= 1'b0;
      stop2_q      <= STOP_ONE;
      tx_serialout <= 1'b1;
      tx_done      <= 1'b0;
    end else begin
      state        <= state_next;
      baud_cnt     <= baud_next;
      bit_idx      <= bit_next;
      tx_serialout <= line_next;
      tx_done      <= done_next;
      if (pop) begin
        data_q   <= fifo_dout;
        par_en_q <= parity_en;
        parity_q <= parity_calc(9'(fifo_dout), parity_type);
        stop2_q  <= stop_bits;
      end
    end
  end

  // Next-state logic; bit_idx counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
          baud_next  = {CNT_W{1'b0}};
          bit_next   = 4'd0;
        end else begin
          baud_next  = {CNT_W{1'b0}};
        end
      end
      START, PARITY: begin
        if (baud_end) begin
          state_next = (state == START) ? DATA : STOP;
          baud_next  = {CNT_W{1'b0}};
          bit_next   = 4'd0;
        end else begin
          baud_next  = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_end && (bit_idx == DATA_LAST)) begin
          state_next = par_en_q ? PARITY : STOP;
          baud_next  = {CNT_W{1'b0}};
          bit_next   = 4'd0;
        end else if (baud_end) begin
          baud_next  = {CNT_W{1'b0}};
          bit_next   = bit_idx + 4'd1;
        end else begin
          baud_next  = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_end && (bit_idx == {3'b000, stop2_q})) begin
          pop        = !fifo_empty;
          state_next = fifo_empty ? IDLE : START;
          baud_next  = {CNT_W{1'b0}};
          bit_next   = 4'd0;
        end else if (baud_end) begin
          baud_next  = {CNT_W{1'b0}};
          bit_next   = bit_idx + 4'd1;
        end else begin
          baud_next  = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = {CNT_W{1'b0}};
        bit_next   = 4'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so the line and done pulse are registered.
  always_comb begin
    line_next = 1'b1;
    done_next = 1'b0;
    case (state_next)
      IDLE:    line_next = 1'b1;
      START:   line_next = 1'b0;
      DATA:    line_next = data_q[bit_next[IDX_W-1:0]];
      PARITY:  line_next = parity_q;
      STOP: begin
        line_next = 1'b1;
        done_next = (baud_next == BAUD_LAST) && (bit_next == {3'b000, stop2_q});
      end
      default: line_next = 1'b1;
    endcase
  end

  // Sticky record of any write refused because the queue was full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (send && fifo_full) begin
      overflow <= 1'b1;
    end else begin
      overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with Data_length=8, FIFO_DEPTH=4, CLKS_PER_BIT=4.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] parallel_datain;
  logic       send;
  logic       parity_en;
  logic       parity_type;
  logic       stop_bits;
  logic       tx_serialout;
  logic       tx_done;
  logic       fifo_full;
  logic       fifo_empty;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(
    .Data_length  (8),
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .parallel_datain (parallel_datain),
    .send            (send),
    .parity_en       (parity_en),
    .parity_type     (parity_type),
    .stop_bits       (stop_bits),
    .tx_serialout    (tx_serialout),
    .tx_done         (tx_done),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .fifo_count      (fifo_count),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line bits of one frame, first bit in index 0.
  task automatic build_frame(input logic [7:0] d, input logic pen, input logic ptype,
                             input logic stop2, output logic [15:0] b, output int n);
    b = 16'hFFFF;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    n = 9;
    if (pen) begin
      b[n] = (^d) ^ ptype;
      n++;
    end
    b[n] = 1'b1;
    n++;
    if (stop2) begin
      b[n] = 1'b1;
      n++;
    end
  endtask

  // Called in the first cycle of a start bit; returns in the cycle after the frame.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic pen,
                             input logic ptype, input logic stop2);
    logic [15:0] b;
    int n;
    build_frame(d, pen, ptype, stop2, b, n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 4; c++) begin
        check({tag, "_line"}, 32'(tx_serialout), 32'(b[k]));
        check({tag, "_done"}, 32'(tx_done), 32'((k == n-1) && (c == 3)));
        tick();
      end
    end
  endtask

  initial begin
    int found;
    rst = 1'b0; send = 1'b0; parallel_datain = 8'h00;
    parity_en = 1'b0; parity_type = 1'b0; stop_bits = 1'b0;

    // Reset held three cycles.
    repeat (3) tick();
    check("rst_line", 32'(tx_serialout), 32'd1);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    rst = 1'b1;
    tick();

    // 0x01, even parity, one stop: 0,1,0,0,0,0,0,0,0,1,1.
    parallel_datain = 8'h01; parity_en = 1'b1; parity_type = 1'b0; stop_bits = 1'b0;
    send = 1'b1;
    tick();
    send = 1'b0;
    check("w1_count", 32'(fifo_count), 32'd1);
    check("w1_idle_line", 32'(tx_serialout), 32'd1);
    tick();
    check("w1_popped", 32'(fifo_count), 32'd0);
    check_frame("f01", 8'h01, 1'b1, 1'b0, 1'b0);
    check("f01_after", 32'(tx_serialout), 32'd1);
    check("f01_empty", 32'(fifo_empty), 32'd1);
    tick();

    // 0x03 then 0x07 back to back: write and pop share an edge.
    parallel_datain = 8'h03; send = 1'b1;
    tick();
    parallel_datain = 8'h07;
    tick();
    send = 1'b0;
    check("wp_count", 32'(fifo_count), 32'd1);
    check_frame("f03", 8'h03, 1'b1, 1'b0, 1'b0);
    check_frame("f07", 8'h07, 1'b1, 1'b0, 1'b0);
    check("f07_idle", 32'(tx_serialout), 32'd1);
    tick();

    // Six writes into a four-deep queue, no parity.
    parity_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      parallel_datain = 8'h10 + 8'(i);
      send = 1'b1;
      tick();
    end
    send = 1'b0;
    check("ov_full", 32'(fifo_full), 32'd1);
    check("ov_count", 32'(fifo_count), 32'd4);
    check("ov_flag", 32'(overflow), 32'd1);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx_done) begin
        found = 1;
        break;
      end
      tick();
    end
    check("ov_first_done", 32'(found), 32'd1);
    tick();
    check_frame("f11", 8'h11, 1'b0, 1'b0, 1'b0);
    check_frame("f12", 8'h12, 1'b0, 1'b0, 1'b0);
    check_frame("f13", 8'h13, 1'b0, 1'b0, 1'b0);
    check_frame("f14", 8'h14, 1'b0, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx_done || !tx_serialout) found++;
      tick();
    end
    check("ov_no_sixth", 32'(found), 32'd0);
    check("ov_empty", 32'(fifo_empty), 32'd1);
    check("ov_sticky", 32'(overflow), 32'd1);

    // 0xFF, odd parity, two stops; options change during the frame.
    parallel_datain = 8'hFF; parity_en = 1'b1; parity_type = 1'b1; stop_bits = 1'b1;
    send = 1'b1;
    tick();
    send = 1'b0;
    tick();
    parity_type = 1'b0; parity_en = 1'b0; stop_bits = 1'b0;
    check_frame("fff", 8'hFF, 1'b1, 1'b1, 1'b1);
    check("fff_idle", 32'(tx_serialout), 32'd1);

    // Reset during DATA with two words queued.
    parallel_datain = 8'h00; send = 1'b1;
    tick();
    parallel_datain = 8'hA5;
    tick();
    parallel_datain = 8'h5A;
    tick();
    send = 1'b0;
    check("mr_count", 32'(fifo_count), 32'd2);
    repeat (8) tick();
    rst = 1'b0; send = 1'b1;
    tick();
    check("mr_line", 32'(tx_serialout), 32'd1);
    check("mr_count0", 32'(fifo_count), 32'd0);
    check("mr_empty", 32'(fifo_empty), 32'd1);
    check("mr_done", 32'(tx_done), 32'd0);
    check("mr_ovf", 32'(overflow), 32'd0);
    tick();
    check("mr_send_ignored", 32'(fifo_count), 32'd0);
    send = 1'b0; rst = 1'b1;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx_done || !tx_serialout) found++;
      tick();
    end
    check("mr_quiet", 32'(found), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter Data_length, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, transmit buffer entries, power of 2 and at least 2.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per serial bit, at least 2.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port parallel_datain, input, Data_length, word to queue.
REQ-007 SHALL have port send, input, 1, write strobe; one word per high cycle.
REQ-008 SHALL have port parity_en, input, 1, 1 = parity bit present.
REQ-009 SHALL have port parity_type, input, 1, 0 = even, 1 = odd.
REQ-010 SHALL have port stop_bits, input, 1, 0 = one stop bit, 1 = two stop bits.
REQ-011 SHALL have port tx_serialout, output, 1, serial line; idles high.
REQ-012 SHALL have port tx_done, output, 1, one-cycle pulse per completed frame.
REQ-013 SHALL have port fifo_full, output, 1; port fifo_empty, output, 1; port fifo_count, output, $clog2(FIFO_DEPTH)+1, current occupancy.
REQ-014 SHALL have port overflow, output, 1, sticky flag for a dropped write.

Function
REQ-015 SHALL accept a write when send=1 and fifo_full=0 at the clock edge; send=1 with fifo_full=1 SHALL drop the word and set overflow, which stays set until reset.
REQ-016 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE with fifo_empty=0 SHALL pop one word at the next edge, capture parity_en, parity_type and stop_bits into frame registers, and enter START; input changes mid-frame SHALL have no effect on that frame.
REQ-018 The start bit SHALL appear on tx_serialout at the first edge after the write edge when the FIFO was empty and the FSM was IDLE (one-cycle latency).
REQ-019 SHALL hold each bit for exactly CLKS_PER_BIT cycles using an internal baud counter; the counter SHALL restart at every pop, with no free-running phase.
REQ-020 Frame order SHALL be: start (0); data LSB first; parity if enabled; 1 or 2 stop bits (1).
REQ-021 Parity bit SHALL be the XOR of the data bits for even, and its inverse for odd.
REQ-022 Frame length SHALL be (1+Data_length+parity_en+1+stop_bits)*CLKS_PER_BIT cycles.
REQ-023 tx_done SHALL pulse high in the final cycle of the last stop bit.
REQ-024 If the FIFO is non-empty at end of stop, the next start bit SHALL follow with no idle cycle; otherwise the FSM SHALL return to IDLE with the line high.
REQ-025 A simultaneous write and pop SHALL both occur and leave fifo_count unchanged; fifo_full SHALL be evaluated before the pop.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-027 With rst=0 at an edge: state IDLE; tx_serialout=1; tx_done=0; FIFO emptied (fifo_empty=1, fifo_full=0, fifo_count=0); overflow=0; baud counter 0.
REQ-028 Reset mid-frame SHALL abort the frame immediately with no tx_done, and discard queued words.
REQ-029 send SHALL be ignored while rst=0.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum and the parity/stop encoding constants.
REQ-031 The buffer SHALL be a separate sub-module uart_sync_fifo (parameters width and depth; push/pop/full/empty/count); uart_tx_fifo instantiates it once.

Verification (Data_length=8, FIFO_DEPTH=4, CLKS_PER_BIT=4)
REQ-032 Reset: hold rst=0 for 3 cycles -> tx_serialout=1, fifo_empty=1, fifo_count=0, overflow=0, tx_done=0.
REQ-033 Write 0x01, even parity, 1 stop -> bits 0,1,0,0,0,0,0,0,0,1,1, each 4 cycles; tx_done pulses 44 cycles after the start bit begins.
REQ-034 Write 0x03 then 0x07 on consecutive cycles -> two contiguous frames with no high gap; tx_done pulses 44 cycles apart.
REQ-035 Write 6 words on consecutive cycles -> first word popped, next 4 fill the FIFO (fifo_full=1, fifo_count=4), 6th dropped, overflow=1; exactly 5 frames transmitted.
REQ-036 Write 0xFF, odd parity, 2 stop bits -> parity bit 1, frame 48 cycles; toggling parity_type mid-frame leaves the frame unchanged.
REQ-037 Assert rst=0 during DATA with 2 words queued -> next edge tx_serialout=1, fifo_count=0; no tx_done follows.
